// File: rtl/bilinear_interp_pkg.sv
// Shared constants, pipeline sideband type and output saturation helper for bilinear_interp.
package bilinear_interp_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned FRAC_W    = 9;
    localparam int unsigned COEF_W    = FRAC_W + 1;
    localparam int unsigned DST_SIZE  = 256;
    localparam int unsigned HSUM_W    = 18;
    localparam int unsigned ACC_W     = 27;
    localparam int unsigned RND_SHIFT = 2 * FRAC_W;
    localparam logic [ACC_W:0] ROUND_CONST = (ACC_W + 1)'(1) << (2 * FRAC_W - 1);

    typedef struct packed {
        logic              valid;
        logic [COEF_W-1:0] c1;
        logic [COEF_W-1:0] c2;
        logic [COEF_W-1:0] c3;
        logic [COEF_W-1:0] c4;
    } stage_t;

    // Drop the fractional bits of a rounded accumulator and clip to the pixel range.
    function automatic logic [DATA_W-1:0] sat_pixel(input logic [ACC_W:0] v);
        logic [ACC_W-RND_SHIFT:0] q;
        q = v[ACC_W:RND_SHIFT];
        if (|q[ACC_W-RND_SHIFT:DATA_W]) begin
            return '1;
        end
        return q[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/bilerp_mac2.sv
// Registered two-term weighted sum a*w0 + b*w1, truncated to OUT_W bits.
module bilerp_mac2 #(
    parameter int unsigned A_W   = 8,
    parameter int unsigned W_W   = 10,
    parameter int unsigned OUT_W = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [A_W-1:0]   a,
    input  logic [A_W-1:0]   b,
    input  logic [W_W-1:0]   w0,
    input  logic [W_W-1:0]   w1,
    output logic [OUT_W-1:0] sum
);

    logic [OUT_W-1:0] sum_d;

    always_comb begin
        sum_d = OUT_W'(a) * OUT_W'(w0) + OUT_W'(b) * OUT_W'(w1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else begin
            sum <= sum_d;
        end
    end

endmodule

// File: rtl/bilinear_interp.sv
// Bilinear interpolation pipeline: clamp/address, memory read, horizontal and vertical
// blend, round/saturate, plus the destination raster counter.
module bilinear_interp #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned FRAC_W   = 9,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DST_SIZE = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        src_width,
    input  logic              in_valid,
    input  logic [9:0]        coordinate_x,
    input  logic [9:0]        coordinate_y,
    input  logic [FRAC_W:0]   coefficient1,
    input  logic [FRAC_W:0]   coefficient2,
    input  logic [FRAC_W:0]   coefficient3,
    input  logic [FRAC_W:0]   coefficient4,
    output logic [ADDR_W-1:0] rd_addr0,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic [ADDR_W-1:0] rd_addr2,
    output logic [ADDR_W-1:0] rd_addr3,
    input  logic [DATA_W-1:0] rd_data0,
    input  logic [DATA_W-1:0] rd_data1,
    input  logic [DATA_W-1:0] rd_data2,
    input  logic [DATA_W-1:0] rd_data3,
    output logic [7:0]        pix_out,
    output logic              pix_valid,
    output logic [7:0]        out_x,
    output logic [7:0]        out_y,
    output logic              frame_done
);

    import bilinear_interp_pkg::*;

    localparam logic [7:0] CNT_LAST = 8'(DST_SIZE - 1);

    logic [9:0]        lim;
    logic [9:0]        x0, x1, y0, y1;
    logic [ADDR_W-1:0] row0, row1;

    always_comb begin
        lim  = {2'b00, src_width} - 10'd1;
        x0   = (coordinate_x > lim) ? lim : coordinate_x;
        y0   = (coordinate_y > lim) ? lim : coordinate_y;
        x1   = (x0 >= lim) ? lim : x0 + 10'd1;
        y1   = (y0 >= lim) ? lim : y0 + 10'd1;
        row0 = ADDR_W'(y0) * ADDR_W'(src_width);
        row1 = ADDR_W'(y1) * ADDR_W'(src_width);
    end

    stage_t st_a, st_b, st_c;
    logic   vld_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr0 <= '0;
            rd_addr1 <= '0;
            rd_addr2 <= '0;
            rd_addr3 <= '0;
            st_a     <= '0;
            st_b     <= '0;
            st_c     <= '0;
            vld_d    <= 1'b0;
        end else begin
            st_a.valid <= in_valid;
            if (in_valid) begin
                rd_addr0 <= row0 + ADDR_W'(x0);
                rd_addr1 <= row0 + ADDR_W'(x1);
                rd_addr2 <= row1 + ADDR_W'(x0);
                rd_addr3 <= row1 + ADDR_W'(x1);
                st_a.c1  <= coefficient1;
                st_a.c2  <= coefficient2;
                st_a.c3  <= coefficient3;
                st_a.c4  <= coefficient4;
            end
            // st_b lines up with rd_data; st_c lines up with the horizontal sums.
            st_b  <= st_a;
            st_c  <= st_b;
            vld_d <= st_c.valid;
        end
    end

    logic [HSUM_W-1:0] top_sum, bot_sum;
    logic [ACC_W-1:0]  acc;

    bilerp_mac2 #(
        .A_W   (DATA_W),
        .W_W   (COEF_W),
        .OUT_W (HSUM_W)
    ) u_mac_top (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (rd_data0),
        .b     (rd_data1),
        .w0    (st_b.c1),
        .w1    (st_b.c2),
        .sum   (top_sum)
    );

    bilerp_mac2 #(
        .A_W   (DATA_W),
        .W_W   (COEF_W),
        .OUT_W (HSUM_W)
    ) u_mac_bot (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (rd_data2),
        .b     (rd_data3),
        .w0    (st_b.c1),
        .w1    (st_b.c2),
        .sum   (bot_sum)
    );

    bilerp_mac2 #(
        .A_W   (HSUM_W),
        .W_W   (COEF_W),
        .OUT_W (ACC_W)
    ) u_mac_vert (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (top_sum),
        .b     (bot_sum),
        .w0    (st_c.c3),
        .w1    (st_c.c4),
        .sum   (acc)
    );

    logic [7:0] pix_d;
    logic [7:0] cnt_x, cnt_y;
    logic       cnt_x_last, cnt_last;

    always_comb begin
        pix_d      = sat_pixel({1'b0, acc} + ROUND_CONST);
        cnt_x_last = (cnt_x == CNT_LAST);
        cnt_last   = cnt_x_last && (cnt_y == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_out    <= '0;
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            cnt_x      <= '0;
            cnt_y      <= '0;
        end else begin
            pix_valid  <= vld_d;
            frame_done <= vld_d && cnt_last;
            if (vld_d) begin
                pix_out <= pix_d;
                out_x   <= cnt_x;
                out_y   <= cnt_y;
                cnt_x   <= cnt_x_last ? 8'd0 : cnt_x + 8'd1;
                if (cnt_x_last) begin
                    cnt_y <= cnt_last ? 8'd0 : cnt_y + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bilinear_interp.sv
// Directed bench for bilinear_interp with a 4-port synchronous-read source memory model.
module tb_bilinear_interp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  src_width;
    logic        in_valid;
    logic [9:0]  coordinate_x, coordinate_y;
    logic [9:0]  coefficient1, coefficient2, coefficient3, coefficient4;
    logic [15:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3;
    logic [7:0]  rd_data0, rd_data1, rd_data2, rd_data3;
    logic [7:0]  pix_out, out_x, out_y;
    logic        pix_valid, frame_done;

    logic [7:0] mem [0:65535];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bilinear_interp dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src_width    (src_width),
        .in_valid     (in_valid),
        .coordinate_x (coordinate_x),
        .coordinate_y (coordinate_y),
        .coefficient1 (coefficient1),
        .coefficient2 (coefficient2),
        .coefficient3 (coefficient3),
        .coefficient4 (coefficient4),
        .rd_addr0     (rd_addr0),
        .rd_addr1     (rd_addr1),
        .rd_addr2     (rd_addr2),
        .rd_addr3     (rd_addr3),
        .rd_data0     (rd_data0),
        .rd_data1     (rd_data1),
        .rd_data2     (rd_data2),
        .rd_data3     (rd_data3),
        .pix_out      (pix_out),
        .pix_valid    (pix_valid),
        .out_x        (out_x),
        .out_y        (out_y),
        .frame_done   (frame_done)
    );

    always @(posedge clk) begin
        rd_data0 <= mem[rd_addr0];
        rd_data1 <= mem[rd_addr1];
        rd_data2 <= mem[rd_addr2];
        rd_data3 <= mem[rd_addr3];
    end

    // Output monitor
    bit mon_en = 1'b0;
    int cyc = 0, n_pix = 0, n_done = 0;
    int done_cyc = 0, done_idx = 0, done_x = -1, done_y = -1;
    int nxt_cyc = 0, nxt_x = -1, nxt_y = -1;

    always @(negedge clk) begin
        cyc++;
        if (mon_en && pix_valid) begin
            n_pix++;
            if (frame_done) begin
                n_done++;
                done_cyc = cyc;
                done_idx = n_pix;
                done_x   = int'(out_x);
                done_y   = int'(out_y);
            end
            if (n_pix == 65537) begin
                nxt_cyc = cyc;
                nxt_x   = int'(out_x);
                nxt_y   = int'(out_y);
            end
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic send(input int cx, input int cy, input int c1, input int c2,
                        input int c3, input int c4);
        coordinate_x = 10'(cx);
        coordinate_y = 10'(cy);
        coefficient1 = 10'(c1);
        coefficient2 = 10'(c2);
        coefficient3 = 10'(c3);
        coefficient4 = 10'(c4);
        in_valid     = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pix(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!pix_valid && lat < 10);
    endtask

    task automatic one_pixel(input string tag, input int cx, input int cy, input int c1,
                             input int c2, input int c3, input int c4, input int exp_pix,
                             input int exp_x);
        int lat;
        send(cx, cy, c1, c2, c3, c4);
        in_valid = 1'b0;
        wait_pix(lat);
        check({tag, "_latency"}, lat, 4);
        check({tag, "_pix"}, pix_out, exp_pix);
        check({tag, "_out_x"}, out_x, exp_x);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        in_valid = 1'b0;
        src_width = 8'd100;
        coordinate_x = '0; coordinate_y = '0;
        coefficient1 = '0; coefficient2 = '0; coefficient3 = '0; coefficient4 = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7);
        mem[2010] = 77;  mem[2011] = 1;   mem[2110] = 2;   mem[2111] = 3;
        mem[4030] = 0;   mem[4031] = 100; mem[4130] = 200; mem[4131] = 255;
        mem[9999] = 123;
        mem[5050] = 255; mem[5051] = 255; mem[5150] = 255; mem[5151] = 255;

        repeat (2) @(posedge clk);
        #1;
        check("rst_pix_valid", pix_valid, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_pix_out", pix_out, 0);
        check("rst_out_x", out_x, 0);
        check("rst_out_y", out_y, 0);
        check("rst_rd_addr0", rd_addr0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Integer coordinate, pass-through of p00
        send(10, 20, 512, 0, 512, 0);
        in_valid = 1'b0;
        check("int_addr0", rd_addr0, 2010);
        check("int_addr1", rd_addr1, 2011);
        check("int_addr2", rd_addr2, 2110);
        check("int_addr3", rd_addr3, 2111);
        wait_pix(lat);
        check("int_latency", lat, 4);
        check("int_pix", pix_out, 77);
        check("int_out_y", out_y, 0);
        check("int_out_x", out_x, 0);

        // Midpoint: (0*256+100*256)*256 + (200*256+255*256)*256 -> 138.75 -> 139
        one_pixel("mid", 30, 40, 256, 256, 256, 256, 139, 1);

        // Edge clamp: all four neighbours collapse onto 9999
        send(99, 99, 384, 128, 384, 128);
        in_valid = 1'b0;
        check("clamp_addr0", rd_addr0, 9999);
        check("clamp_addr1", rd_addr1, 9999);
        check("clamp_addr2", rd_addr2, 9999);
        check("clamp_addr3", rd_addr3, 9999);
        wait_pix(lat);
        check("clamp_pix", pix_out, 123);

        // Beyond-range coordinate clamps as well
        send(500, 300, 512, 0, 512, 0);
        in_valid = 1'b0;
        check("clamp_far_addr0", rd_addr0, 9999);
        wait_pix(lat);

        // 255*513*512 rounds to 255.998 -> 255
        one_pixel("round", 50, 50, 512, 1, 512, 0, 255, 4);
        // 255*512*612 -> 305.3, must clip to 255 rather than wrap to 49
        one_pixel("sat", 50, 50, 512, 0, 512, 100, 255, 5);

        // Mid-stream reset with pixels in flight
        send(10, 20, 512, 0, 512, 0);
        send(30, 40, 256, 256, 256, 256);
        send(50, 50, 512, 0, 512, 0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("pre_rst_valid", pix_valid, 1);
        check("pre_rst_out_x", out_x, 6);
        rst_n = 1'b0;
        #1;
        check("midrst_pix_valid", pix_valid, 0);
        check("midrst_out_x", out_x, 0);
        check("midrst_out_y", out_y, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("no_stale_pixel", n_pix, 0);

        // Full frame with random bubbles, then the next frame's first input back-to-back
        for (int n = 0; n < 65536; ) begin
            if (n > 0 && $urandom_range(0, 15) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end else begin
                send($urandom_range(0, 120), $urandom_range(0, 120), 256, 256, 300, 212);
                n++;
            end
        end
        send(10, 20, 512, 0, 512, 0);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("frame_pix_count", n_pix, 65537);
        check("frame_done_pulses", n_done, 1);
        check("frame_done_index", done_idx, 65536);
        check("frame_done_x", done_x, 255);
        check("frame_done_y", done_y, 255);
        check("next_frame_gap", nxt_cyc - done_cyc, 1);
        check("next_frame_x", nxt_x, 0);
        check("next_frame_y", nxt_y, 0);
        check("frame_done_clear", frame_done, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bilinear_interp.md
# bilinear_interp

Bilinear interpolation datapath that sits directly downstream of the coordinate/coefficient generator.
- For every valid destination sample it fetches the four neighbouring source pixels from a 4-port source-frame memory.
- It blends them with the supplied 9-bit fractional weights and emits one 8-bit destination pixel per cycle, in raster order.
- It keeps a destination pixel counter and flags end-of-frame for the frame writer.

## Interface
Parameters:
- DATA_W, 8, pixel width
- FRAC_W, 9, fractional bits; a weight of 2^FRAC_W = 512 means 1.0
- ADDR_W, 16, source memory address width
- DST_SIZE, 256, destination width = height

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- src_width  in  8  source width = source height; static during a frame
- in_valid  in  1  coordinate/coefficient inputs valid this cycle
- coordinate_x, coordinate_y  in  10 each  integer source coordinate
- coefficient1  in  10  weight of column x0 (512 − frac_x)
- coefficient2  in  10  weight of column x1 (frac_x)
- coefficient3  in  10  weight of row y0 (512 − frac_y)
- coefficient4  in  10  weight of row y1 (frac_y)
- rd_addr0..rd_addr3  out  ADDR_W each  addresses of p00, p01, p10, p11
- rd_data0..rd_data3  in  DATA_W each  synchronous-read data, one cycle after the address
- pix_out  out  8  interpolated pixel
- pix_valid  out  1  pix_out valid
- out_x, out_y  out  8 each  destination coordinate of pix_out
- frame_done  out  1  one-cycle pulse with the last pixel of a frame

## Operation
- Stage A (edge E0, in_valid sampled high): address generation.
  - Clamping, with L = src_width − 1: x0 = min(coordinate_x, L); x1 = min(x0 + 1, L); y0 and y1 likewise.
  - Addresses, computed at ADDR_W width: rd_addr0 = y0·src_width + x0; rd_addr1 = y0·src_width + x1; rd_addr2 = y1·src_width + x0; rd_addr3 = y1·src_width + x1.
  - rd_addr* are registered outputs. The four coefficients are registered and travel alongside the data.
- Stage B (E1): memory returns p00, p01, p10, p11.
- Stage C (E2): horizontal blend, registered as unsigned 18-bit values.
  - top = p00·c1 + p01·c2
  - bot = p10·c1 + p11·c2
  - Each is ≤ 255·512.
- Stage D (E3): vertical blend, acc = top·c3 + bot·c4, 27-bit unsigned.
- Stage E (E4): pix_out = (acc + 2^17) >> 18, saturated to 255. pix_valid = 1.
- A valid bit travels through every stage. Bubbles (in_valid = 0) propagate unchanged; there is no backpressure.
- Destination counter:
  - out_x increments on each output pixel and wraps from DST_SIZE−1 to 0.
  - out_y increments on that wrap.
  - frame_done = 1 with the pixel at (255, 255); both counters then return to 0.
- Weights summing to ≠ 512 are not checked; the result is still saturated.

## Timing
- Latency: the input sampled at E0 appears on pix_out/pix_valid after E4, i.e. 4 clocks later. Throughput is 1 pixel/clock.
- Reset (asynchronous, rst_n low):
  - Outputs: pix_valid = 0, frame_done = 0, pix_out = 0, out_x = out_y = 0, rd_addr* = 0.
  - All stage valid bits are cleared.
- Reset mid-frame: in-flight samples are discarded and no pix_valid follows. The counter restarts at (0, 0).
- Coincident events: the in_valid edge at which stage E emits the last pixel is handled independently; the next frame's first input is accepted with no dead cycle.
- src_width changes mid-frame are undefined.

## Structure
- A shared package holds:
  - FRAC_W, DATA_W, the rounding constant 2^(2·FRAC_W − 1), DST_SIZE;
  - the stage-valid/sideband struct (coefficients plus valid).
- One sub-module, `bilerp_mac2`: registered two-term weighted sum a·w0 + b·w1. It is instantiated three times (top, bot, vertical), with widths set by parameter.
- Address clamp/multiply stays in the top level.

## Test plan
- Reset: assert rst_n = 0 mid-stream -> pix_valid = 0 and out_x = out_y = 0 immediately; no stale pixel after release.
- Integer coordinate: src_width = 100, coordinate (10, 20), c1 = c3 = 512, c2 = c4 = 0, memory[2010] = 77 -> pix_out = 77 exactly 4 clocks after in_valid; rd_addr0 = 2010, rd_addr1 = 2011, rd_addr2 = 2110, rd_addr3 = 2111.
- Midpoint: p00 = 0, p01 = 100, p10 = 200, p11 = 255, all coefficients 256 -> pix_out = 139 (138.75 rounded).
- Edge clamp: coordinate (99, 99), src_width = 100 -> all four rd_addr = 9999; pix_out = memory[9999].
- Saturation/round: all pixels 255, c1 = 512, c2 = 1 -> pix_out = 255, no wrap.
- Full frame: 65536 back-to-back in_valid with random bubbles -> exactly 65536 pix_valid; frame_done single pulse coincident with out_x = out_y = 255; the next input is accepted on the following clock.
